// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the dsp_sys_arr datapath: FIFO word type and the
// tile-reader state encoding.
package dsp_sys_arr_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } rd_state_t;

endpackage

// File: rtl/FIFO_if.sv
// FIFO access bundle: first-word-fall-through read side plus push side.
interface FIFO_if
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  parameter int unsigned BW   = 1
);

  logic                      push;
  logic                      pop;
  logic                      is_full;
  logic                      is_empty;
  word_t [BW-1:0]            dat_in;
  word_t [BW-1:0]            dat_out;
  logic [$clog2(SIZE+1)-1:0] ocp;

  modport master (
    output push, pop, dat_in,
    input  is_full, is_empty, dat_out, ocp
  );

endinterface

// File: rtl/stream_skid2.sv
// Generic 2-entry valid/ready buffer; entry e0 is always the head.
module stream_skid2 #(
  parameter type T = logic
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  T           in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output T           out_data,
  output logic [1:0] count
);

  T           e0;
  T           e1;
  logic [1:0] cnt;
  logic       accept;

  assign accept    = (cnt != 2'd0) && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign count     = cnt;

  // Caller never pushes while cnt==2, so no overflow handling here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (clear) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({in_valid, accept})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains one tile of tile_len beats from a FWFT FIFO and presents it as a
// valid/ready stream with a last-beat flag.
module fifo_stream_reader
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned BW    = 1,
  parameter int unsigned LEN_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  FIFO_if.master           fif,
  input  logic             start,
  input  logic [LEN_W-1:0] tile_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t [BW-1:0]   out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    word_t [BW-1:0] data;
    logic           last;
  } beat_t;

  rd_state_t        state;
  rd_state_t        state_nx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] popped;
  logic [LEN_W-1:0] sent;
  logic [1:0]       buf_cnt;
  logic             do_pop;
  logic             accept;
  logic             finish;
  logic             cancel;
  logic             done_nx;
  beat_t            in_beat;
  beat_t            head;

  logic [$clog2(SIZE+1)-1:0] unused_ocp;
  logic                      unused_full;
  assign unused_ocp  = fif.ocp;
  assign unused_full = fif.is_full;

  assign cancel  = abort && (state != IDLE);
  assign do_pop  = (state == STREAM) && !fif.is_empty && (popped != len) &&
                   (buf_cnt < 2'd2) && !abort;
  assign accept  = out_valid && out_ready;
  // Completion is taken from the accept of the final beat so that done
  // lands one cycle after it rather than a cycle later via FLUSH.
  assign finish  = accept && (sent == len - 1'b1) && (state != IDLE);

  assign in_beat.data = fif.dat_out;
  assign in_beat.last = (popped == len - 1'b1);

  assign fif.pop    = do_pop;
  assign fif.push   = 1'b0;
  assign fif.dat_in = '0;

  assign out_data = head.data;
  assign out_last = head.last;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (tile_len != '0) state_nx = STREAM;
          else                done_nx  = 1'b1;
        end
      end
      STREAM: begin
        if (finish) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (popped == len) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (finish) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (cancel) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      done   <= 1'b0;
      len    <= '0;
      popped <= '0;
      sent   <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (state == IDLE) begin
        if (start && (tile_len != '0)) begin
          len    <= tile_len;
          popped <= '0;
          sent   <= '0;
        end
      end else if (state_nx == IDLE) begin
        len    <= '0;
        popped <= '0;
        sent   <= '0;
      end else begin
        if (do_pop) popped <= popped + 1'b1;
        if (accept) sent   <= sent + 1'b1;
      end
    end
  end

  stream_skid2 #(
    .T (beat_t)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (nRST),
    .clear     (cancel),
    .in_valid  (do_pop),
    .in_data   (in_beat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (head),
    .count     (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FWFT FIFO.
module tb_fifo_stream_reader;
  import dsp_sys_arr_pkg::*;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned BW    = 1;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned OCP_W = $clog2(SIZE + 1);

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic [LEN_W-1:0] tile_len = '0;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             done;
  word_t [BW-1:0]   out_data;

  FIFO_if #(.SIZE(SIZE), .BW(BW)) fif ();

  fifo_stream_reader #(.SIZE(SIZE), .BW(BW), .LEN_W(LEN_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .fif       (fif),
    .start     (start),
    .tile_len  (tile_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    word_t data;
    logic  last;
  } exp_t;

  word_t fq[$];
  exp_t  sb[$];
  logic  push_req = 1'b0;
  word_t push_dat = '0;
  logic  flush_req = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int acc_cnt = 0;
  int acc_first = 0;
  int acc_last = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge CLK) begin
    cyc++;
    if (fif.pop && fq.size() > 0) void'(fq.pop_front());
    if (flush_req) fq.delete();
    if (push_req) fq.push_back(push_dat);
    fif.is_empty   <= (fq.size() == 0);
    fif.is_full    <= (fq.size() >= SIZE);
    fif.dat_out[0] <= (fq.size() != 0) ? fq[0] : '0;
    fif.ocp        <= OCP_W'(fq.size());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic  hold_prev = 1'b0;
  word_t data_prev = '0;
  logic  last_prev = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (!nRST) begin
      hold_prev = 1'b0;
    end else begin
      if (fif.pop) begin
        pop_cnt++;
        check("pop_while_empty", 32'(fif.is_empty), 32'd0);
      end
      if (hold_prev && out_valid) begin
        check("hold_data", 32'(out_data[0]), 32'(data_prev));
        check("hold_last", 32'(out_last), 32'(last_prev));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", out_data[0]);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(out_data[0]), 32'(e.data));
          check("beat_last", 32'(out_last), 32'(e.last));
        end
        if (acc_cnt == 0) acc_first = cyc;
        acc_last = cyc;
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data[0];
      last_prev = out_last;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input word_t d);
    push_req = 1'b1;
    push_dat = d;
    step();
    push_req = 1'b0;
  endtask

  task automatic prefill(input word_t base, input int n, input bit record);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (record) begin
        e.data = base + word_t'(i);
        e.last = (i == n - 1);
        sb.push_back(e);
      end
      push_word(base + word_t'(i));
    end
  endtask

  task automatic go(input int n);
    tile_len = LEN_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no done pulse expected done within %0d cycles", name, max);
    end
  endtask

  task automatic flush_fifo();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data[0]), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pop"},   32'(fif.pop), 32'd0);
  endtask

  initial begin
    int p0;
    int d0;
    exp_t e;

    repeat (2) @(posedge CLK);
    #3;
    check_zero_outputs("reset");
    check("reset_push", 32'(fif.push), 32'd0);
    check("reset_dat_in", 32'(fif.dat_in[0]), 32'd0);
    step();
    nRST = 1'b1;
    step();
    step();

    // T1: prefilled tile, free-running consumer
    out_ready = 1'b1;
    prefill(16'h11, 4, 1'b1);
    acc_cnt = 0;
    d0 = done_cnt;
    go(4);
    wait_done(20, "t1_done");
    check("t1_busy_at_done", 32'(busy), 32'd0);
    step();
    check("t1_beats", 32'(acc_cnt), 32'd4);
    check("t1_span", 32'(acc_last - acc_first), 32'd3);
    check("t1_done_latency", 32'(done_cyc - acc_last), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) step();
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // T2: backpressure for 5 cycles
    out_ready = 1'b0;
    prefill(16'h11, 4, 1'b1);
    acc_cnt = 0;
    p0 = pop_cnt;
    go(4);
    repeat (5) step();
    check("t2_pops_held", 32'(pop_cnt - p0), 32'd2);
    check("t2_head", 32'(out_data[0]), 32'h11);
    check("t2_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done(20, "t2_done");
    step();
    check("t2_beats", 32'(acc_cnt), 32'd4);
    check("t2_pops", 32'(pop_cnt - p0), 32'd4);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // T3: FIFO underflow, words trickle in
    out_ready = 1'b1;
    acc_cnt = 0;
    p0 = pop_cnt;
    go(3);
    step();
    check("t3_no_pop_empty", 32'(fif.pop), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      e.data = 16'hA0 + word_t'(i);
      e.last = (i == 2);
      sb.push_back(e);
      push_word(16'hA0 + word_t'(i));
      @(negedge CLK);
      check("t3_pop_on_visible", 32'(fif.pop), 32'd1);
      @(negedge CLK);
      check("t3_beat_valid", 32'(out_valid), 32'd1);
      check("t3_beat_data", 32'(out_data[0]), 32'(16'hA0 + i));
      if (i < 2) begin
        step();
        check("t3_gap", 32'(out_valid), 32'd0);
      end
    end
    wait_done(5, "t3_done");
    step();
    check("t3_beats", 32'(acc_cnt), 32'd3);
    check("t3_pops", 32'(pop_cnt - p0), 32'd3);

    // T4: zero-length tile
    p0 = pop_cnt;
    d0 = done_cnt;
    go(0);
    @(negedge CLK);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("t4_done_pulse", 32'(done), 32'd0);
    step();
    check("t4_no_pop", 32'(pop_cnt - p0), 32'd0);
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // T5: abort after three accepts
    out_ready = 1'b1;
    prefill(16'h30, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e.data = 16'h30 + word_t'(i);
      e.last = 1'b0;
      sb.push_back(e);
    end
    acc_cnt = 0;
    d0 = done_cnt;
    go(8);
    repeat (4) step();
    out_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_accepts", 32'(acc_cnt), 32'd3);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_fifo_left", 32'(fq.size()), 32'd4);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    out_ready = 1'b1;
    repeat (4) step();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);
    flush_fifo();

    // T6: asynchronous reset mid-tile, then a fresh tile
    out_ready = 1'b0;
    prefill(16'h41, 4, 1'b0);
    go(4);
    repeat (3) step();
    #3;
    nRST = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    check("t6_fifo_kept", 32'(fq.size()), 32'd2);
    flush_fifo();
    nRST = 1'b1;
    step();
    out_ready = 1'b1;
    prefill(16'h51, 2, 1'b1);
    acc_cnt = 0;
    go(2);
    wait_done(20, "t6_done");
    step();
    check("t6_beats", 32'(acc_cnt), 32'd2);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected bench completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master of FIFO_if: drains one tile of exactly tile_len BW-wide words from a FIFO and presents them as a valid/ready stream with a last-beat flag.
- Sits between the input FIFOs and the systolic-array row feeders in the dsp_sys_arr datapath.
- A 2-entry output buffer gives 1 beat/cycle throughput.
- pop never depends combinationally on out_ready.

Parameters:
- SIZE, 16, depth of the attached FIFO (sizes the FIFO_if ocp field only)
- BW, 1, words per beat; must match the attached FIFO_if BW
- LEN_W, 16, width of tile_len and the internal beat counters

Ports:
- CLK  input  1  single clock, all state on rising edge
- nRST  input  1  asynchronous, active-low reset
- fif  interface  FIFO_if.master (SIZE, BW)  push/pop/dat_in driven; is_full/is_empty/dat_out/ocp sampled
- start  input  1  launches a tile read; sampled in IDLE only
- tile_len  input  LEN_W  beats in the tile, latched on accepted start
- abort  input  1  synchronous cancel, highest priority after reset
- out_valid  output  1  out_data/out_last are valid
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready
- out_data  output  word_t[BW-1:0]  beat payload
- out_last  output  1  high on the final beat of the tile
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when a tile is fully delivered

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state=IDLE; buffer count=0; all counters=0; out_valid, out_last, busy, done, fif.pop, fif.push = 0; out_data = 0.
- FIFO semantics (fixed): first-word-fall-through. fif.dat_out is the head whenever !is_empty; asserting pop consumes the head at the clock edge.
- fif.push=0 and fif.dat_in='0 always.
- States:
  - IDLE -> STREAM on start && tile_len!=0; latch len, set popped=0 and sent=0.
  - IDLE with start && tile_len==0: stay in IDLE, pulse done on the next cycle, no beats.
  - STREAM -> FLUSH when popped==len. FLUSH -> IDLE when buffer is empty and sent==len; done pulses in the cycle IDLE is entered.
  - start while busy is ignored.
- Pop rule: fif.pop = (state==STREAM) && !is_empty && (popped!=len) && (buf_cnt<2).
  - Each pop writes fif.dat_out into the buffer tail and increments popped.
- Buffer:
  - 2-entry FIFO of {data, last}. out_valid = buf_cnt!=0; head drives out_data/out_last.
  - Simultaneous push-in and accept leaves buf_cnt unchanged.
  - An entry's last bit is set when popped==len-1 at the time of its pop.
- Latency: head word appears on out_* 1 cycle after its pop. Steady state with out_ready=1 and non-empty FIFO runs at 1 beat/cycle, with buf_cnt oscillating 0->1 then holding 1.
- Backpressure: out_ready=0 lets the buffer fill to 2, then pop deasserts. Data is never dropped or duplicated, and out_data/out_last stay stable while out_valid && !out_ready.
- FIFO underflow: is_empty stalls pop, leaving a gap in out_valid. No timeout.
- Abort: next state is IDLE, buffer cleared, counters cleared, no done pulse. Words already popped are discarded. Abort in IDLE has no effect.
- Reset mid-tile: immediate async clear to reset values. FIFO contents are untouched.
- Counters: popped and sent are LEN_W bits and cannot wrap, because both are bounded by len.

Decomposition:
- dsp_sys_arr_pkg: word_t (existing); add rd_state_t enum {IDLE, STREAM, FLUSH}.
- One sub-module: stream_skid2, a generic 2-entry valid/ready buffer parameterised on payload type. Reused by the future writer side.
- Top module holds the FSM, counters and pop logic.

Test Plan:
- Prefill 4 words 0x11..0x14, BW=1, start with tile_len=4, out_ready=1:
  - 4 consecutive beats 0x11..0x14; out_last only on 0x14.
  - done pulses exactly once, 1 cycle after the last accept; busy drops in the same cycle.
- Same prefill, out_ready=0 for 5 cycles, then 1:
  - pop stops after 2 pops; out_data holds 0x11 stable.
  - All 4 beats delivered in order, no loss or duplicate.
- FIFO empty at start, tile_len=3; push 0xA0, 0xA1, 0xA2 at cycles 3, 6, 9:
  - each beat appears 1 cycle after its push becomes visible; pop never asserted while is_empty.
- tile_len=0 with start: no out_valid, no pop, done pulse 1 cycle later.
- tile_len=8, abort after 3 accepts: IDLE next cycle, out_valid=0, no done; the FIFO retains 8-3-(buffered count) words.
- nRST low mid-tile (asynchronous, between edges): all outputs zero immediately. After release, a new start with tile_len=2 streams correctly.
